// File: rtl/lioncage_pkg.sv
// Shared types and constants for the lion-cage gate front end.
// - state_e : passage-tracking FSM states (3-bit)
// - event_e : which count pulse, if any, a transition produces
// - GC_*    : debounced gate codes, packed as {a, b}
package lioncage_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IN_A     = 3'd1,
    IN_AB    = 3'd2,
    IN_B     = 3'd3,
    OUT_B    = 3'd4,
    OUT_AB   = 3'd5,
    OUT_A    = 3'd6,
    WAIT_CLR = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_ENTER = 2'd1,
    EV_EXIT  = 2'd2,
    EV_ABORT = 2'd3
  } event_e;

  localparam logic [1:0] GC_CLR = 2'b00;
  localparam logic [1:0] GC_A   = 2'b10;
  localparam logic [1:0] GC_B   = 2'b01;
  localparam logic [1:0] GC_AB  = 2'b11;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a level debouncer for one light gate.
// A new synced level must persist for DB_CYCLES consecutive cycles before it
// appears on 'level'; shorter glitches are discarded.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high
//   raw   - asynchronous gate input, 1 = beam broken
//   level - debounced gate level
module debounce_filter #(
  parameter int unsigned DB_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        // Mismatch has now held for DB_CYCLES cycles: accept the new level.
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/gate_direction_decoder.sv
// Direction decoder for the lion-cage gate pair (A outside, B inside).
// Debounces both gates, tracks a full passage and emits one-cycle
// enter/exit pulses; abandoned or illegal passages yield abort_pulse only.
// Ports:
//   clk, reset              - clock; synchronous active-high reset
//   gate_a_raw, gate_b_raw  - asynchronous gate inputs, 1 = beam broken
//   gate_a, gate_b          - debounced gate levels
//   enter_pulse             - completed A -> AB -> B -> clear passage
//   exit_pulse              - completed B -> AB -> A -> clear passage
//   abort_pulse             - passage abandoned, illegal or timed out
//   busy                    - FSM not in IDLE
module gate_direction_decoder
  import lioncage_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000,
  parameter int unsigned TO_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic gate_a_raw,
  input  logic gate_b_raw,
  output logic gate_a,
  output logic gate_b,
  output logic enter_pulse,
  output logic exit_pulse,
  output logic abort_pulse,
  output logic busy
);

  localparam int unsigned ToW = $clog2(TO_CYCLES);
  localparam logic [ToW-1:0] ToMax = ToW'(TO_CYCLES - 1);

  state_e         state_q, state_d;
  event_e         ev_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]     code;

  debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk   (clk),
    .reset (reset),
    .raw   (gate_a_raw),
    .level (gate_a)
  );

  debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk   (clk),
    .reset (reset),
    .raw   (gate_b_raw),
    .level (gate_b)
  );

  assign code = {gate_a, gate_b};

  always_comb begin
    state_d  = state_q;
    ev_d     = EV_NONE;
    to_cnt_d = '0;

    // Transition table; anything not listed as legal jumps to WAIT_CLR with abort.
    unique case (state_q)
      IDLE: begin
        case (code)
          GC_A:    state_d = IN_A;
          GC_B:    state_d = OUT_B;
          GC_AB:   begin state_d = WAIT_CLR; ev_d = EV_ABORT; end
          default: ;
        endcase
      end
      IN_A: begin
        case (code)
          GC_AB:   state_d = IN_AB;
          GC_CLR:  begin state_d = IDLE;     ev_d = EV_ABORT; end
          GC_B:    begin state_d = WAIT_CLR; ev_d = EV_ABORT; end
          default: ;
        endcase
      end
      IN_AB: begin
        case (code)
          GC_B:    state_d = IN_B;
          GC_A:    state_d = IN_A;
          GC_CLR:  begin state_d = WAIT_CLR; ev_d = EV_ABORT; end
          default: ;
        endcase
      end
      IN_B: begin
        case (code)
          GC_CLR:  begin state_d = IDLE; ev_d = EV_ENTER; end
          GC_AB:   state_d = IN_AB;
          GC_A:    begin state_d = WAIT_CLR; ev_d = EV_ABORT; end
          default: ;
        endcase
      end
      OUT_B: begin
        case (code)
          GC_AB:   state_d = OUT_AB;
          GC_CLR:  begin state_d = IDLE;     ev_d = EV_ABORT; end
          GC_A:    begin state_d = WAIT_CLR; ev_d = EV_ABORT; end
          default: ;
        endcase
      end
      OUT_AB: begin
        case (code)
          GC_A:    state_d = OUT_A;
          GC_B:    state_d = OUT_B;
          GC_CLR:  begin state_d = WAIT_CLR; ev_d = EV_ABORT; end
          default: ;
        endcase
      end
      OUT_A: begin
        case (code)
          GC_CLR:  begin state_d = IDLE; ev_d = EV_EXIT; end
          GC_AB:   state_d = OUT_AB;
          GC_B:    begin state_d = WAIT_CLR; ev_d = EV_ABORT; end
          default: ;
        endcase
      end
      WAIT_CLR: begin
        if (code == GC_CLR) state_d = IDLE;
      end
      default: begin
        state_d = WAIT_CLR;
      end
    endcase

    // The stall timer only runs while a passage is in progress and the state holds;
    // any transition wins over an expiring timer and clears it.
    if (state_q != IDLE && state_q != WAIT_CLR && state_d == state_q) begin
      if (to_cnt_q == ToMax) begin
        state_d = WAIT_CLR;
        ev_d    = EV_ABORT;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      abort_pulse <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      enter_pulse <= (ev_d == EV_ENTER);
      exit_pulse  <= (ev_d == EV_EXIT);
      abort_pulse <= (ev_d == EV_ABORT);
      busy        <= (state_d != IDLE);
    end
  end

endmodule
